// File: rtl/cacheline_burst_adaptor.sv
// Converts whole-cacheline read/write requests into fixed-length bursts of BEATS memory beats.
// Optional checking of upstream/downstream protocol misuse is enabled with BURST_PROTOCOL_CHECK_EN.
module cacheline_burst_adaptor #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int BEATS      = LINE_WIDTH / BEAT_WIDTH,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic                  read_i,
  input  logic                  write_i,
  input  logic [LINE_WIDTH-1:0] line_i,
  output logic [LINE_WIDTH-1:0] line_o,
  output logic                  resp_o,
  output logic [ADDR_WIDTH-1:0] address_o,
  output logic                  read_o,
  output logic                  write_o,
  output logic [BEAT_WIDTH-1:0] burst_o,
  input  logic [BEAT_WIDTH-1:0] burst_i,
  input  logic                  resp_i,
  output logic                  proto_err_o
);

  localparam int OFFSET = $clog2(LINE_WIDTH / 8);
  localparam int CNT_W  = $clog2(BEATS);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << OFFSET) - ADDR_WIDTH'(1));
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  // state_q is the observation point for the FSM.
  state_t                state_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_nx;
  logic [LINE_WIDTH-1:0] line_q;

  assign count_nx = count_q + CNT_W'(1);
  assign line_o   = line_q;

  // Handshake: read_i/write_i are held by upstream until the one-cycle resp_o pulse;
  // downstream read_o/write_o stay high for the whole burst and each cycle with
  // resp_i high transfers exactly one beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      line_q    <= '0;
      resp_o    <= 1'b0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      burst_o   <= '0;
    end else begin
      resp_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (read_i) begin
            address_o <= address_i & ALIGN_MASK;
            read_o    <= 1'b1;
            state_q   <= RD;
          end else if (write_i) begin
            address_o <= address_i & ALIGN_MASK;
            line_q    <= line_i;
            burst_o   <= line_i[0 +: BEAT_WIDTH];
            write_o   <= 1'b1;
            state_q   <= WR;
          end
        end
        RD: begin
          if (resp_i) begin
            line_q[count_q*BEAT_WIDTH +: BEAT_WIDTH] <= burst_i;
            count_q <= count_nx;
            if (count_q == LAST) begin
              read_o  <= 1'b0;
              state_q <= DONE;
            end
          end
        end
        WR: begin
          if (resp_i) begin
            count_q <= count_nx;
            if (count_q == LAST) begin
              write_o <= 1'b0;
              burst_o <= '0;
              state_q <= DONE;
            end else begin
              burst_o <= line_q[count_nx*BEAT_WIDTH +: BEAT_WIDTH];
            end
          end
        end
        DONE: begin
          resp_o  <= 1'b1;
          count_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef BURST_PROTOCOL_CHECK_EN
  logic [ADDR_WIDTH-1:0] addr_prev_q;
  logic                  err_stray_resp;
  logic                  err_both_req;
  logic                  err_addr_change;

  always_comb begin
    err_stray_resp  = resp_i && (state_q == IDLE || state_q == DONE);
    err_both_req    = read_i && write_i && (state_q == IDLE);
    err_addr_change = (state_q == RD || state_q == WR) && (address_i != addr_prev_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err_o <= 1'b0;
      addr_prev_q <= '0;
    end else begin
      addr_prev_q <= address_i;
      if (err_stray_resp || err_both_req || err_addr_change) proto_err_o <= 1'b1;
    end
  end

  a_stray_resp: assert property (@(posedge clk) disable iff (rst) !err_stray_resp)
    else $warning("resp_i asserted while no burst is active");
  a_both_req: assert property (@(posedge clk) disable iff (rst) !err_both_req)
    else $warning("read_i and write_i both asserted in IDLE");
  a_addr_change: assert property (@(posedge clk) disable iff (rst) !err_addr_change)
    else $warning("address_i changed during a burst");
`else
  assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench for cacheline_burst_adaptor: a vector table for a basic read burst plus
// hand-written sequences for stalled writes, simultaneous requests, back-to-back and reset.
module tb_cacheline_burst_adaptor;

  logic         clk;
  logic         rst;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         resp_i;
  logic         proto_err_o;

  cacheline_burst_adaptor dut (
    .clk        (clk),
    .rst        (rst),
    .address_i  (address_i),
    .read_i     (read_i),
    .write_i    (write_i),
    .line_i     (line_i),
    .line_o     (line_o),
    .resp_o     (resp_o),
    .address_o  (address_o),
    .read_o     (read_o),
    .write_o    (write_o),
    .burst_o    (burst_o),
    .burst_i    (burst_i),
    .resp_i     (resp_i),
    .proto_err_o(proto_err_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int resp_cnt;

  always @(negedge clk) if (resp_o === 1'b1) resp_cnt++;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic         rsp;
    logic [63:0]  beat;
    logic         e_rd;
    logic         e_wr;
    logic         e_resp;
    logic [31:0]  e_addr;
    logic         chk_line;
    logic [255:0] e_line;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(logic rd, logic wr, logic [31:0] addr, logic rsp, logic [63:0] beat,
                              logic e_rd, logic e_wr, logic e_resp, logic [31:0] e_addr,
                              logic chk_line, logic [255:0] e_line);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.rsp = rsp; v.beat = beat;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_resp = e_resp; v.e_addr = e_addr;
    v.chk_line = chk_line; v.e_line = e_line;
    return v;
  endfunction

  function automatic logic [63:0] slot(logic [255:0] l, int k);
    return l[k*64 +: 64];
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // Issues a read, returns beats back-to-back and checks the completion.
  task automatic read_burst(input logic [31:0] addr, input logic [255:0] data, input logic keep_req);
    read_i    = 1'b1;
    address_i = addr;
    tick();
    check("rd_accept_read_o", 256'(read_o), 256'(1'b1));
    check("rd_accept_write_o", 256'(write_o), 256'(1'b0));
    check("rd_accept_addr", 256'(address_o), 256'(addr & 32'hFFFF_FFE0));
    for (int k = 0; k < 4; k++) begin
      resp_i  = 1'b1;
      burst_i = slot(data, k);
      tick();
      check("rd_beat_read_o", 256'(read_o), 256'(k < 3));
      check("rd_beat_write_o", 256'(write_o), 256'(1'b0));
      check("rd_beat_resp_o", 256'(resp_o), 256'(1'b0));
    end
    resp_i  = 1'b0;
    burst_i = '0;
    tick();
    check("rd_done_resp_o", 256'(resp_o), 256'(1'b1));
    check("rd_done_line_o", line_o, data);
    read_i = keep_req;
  endtask

  logic [255:0] w_line;
  logic [255:0] d1, d2, d3, d4;
  logic [63:0]  b1, b2, b3, b4;
  logic         exp_proto;
  int           resp_base;

  initial begin
    checks   = 0;
    errors   = 0;
    resp_cnt = 0;
`ifdef BURST_PROTOCOL_CHECK_EN
    exp_proto = 1'b1;
`else
    exp_proto = 1'b0;
`endif
    b1 = 64'h1111_1111_1111_1111;
    b2 = 64'h2222_2222_2222_2222;
    b3 = 64'h3333_3333_3333_3333;
    b4 = 64'h4444_4444_4444_4444;
    w_line = 256'hDEAD0000_11111111_22222222_33333333_44444444_55555555_66666666_0000BEEF;
    d1 = 256'hA1A1A1A1_A2A2A2A2_A3A3A3A3_A4A4A4A4_A5A5A5A5_A6A6A6A6_A7A7A7A7_A8A8A8A8;
    d2 = 256'h0102030405060708_1112131415161718_2122232425262728_3132333435363738;
    d3 = 256'hCAFEF00D_00000001_CAFEF00D_00000002_CAFEF00D_00000003_CAFEF00D_00000004;
    d4 = 256'h5555AAAA_5555AAAA_0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0_FEDCBA98_76543210;

    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; address_i = '0;
    line_i = '0; burst_i = '0; resp_i = 1'b0;
    #12;
    check("reset_read_o", 256'(read_o), 256'(1'b0));
    check("reset_write_o", 256'(write_o), 256'(1'b0));
    check("reset_resp_o", 256'(resp_o), 256'(1'b0));
    check("reset_address_o", 256'(address_o), 256'(32'h0));
    check("reset_burst_o", 256'(burst_o), 256'(64'h0));
    check("reset_line_o", line_o, 256'h0);
    check("reset_proto_err_o", 256'(proto_err_o), 256'(1'b0));
    rst = 1'b0;

    // Read 0x1234 with back-to-back beats, then a stray resp_i while idle.
    vecs[0] = mk(1, 0, 32'h1234, 0, 64'h0, 1, 0, 0, 32'h1220, 0, '0);
    vecs[1] = mk(1, 0, 32'h1234, 1, b1,    1, 0, 0, 32'h1220, 0, '0);
    vecs[2] = mk(1, 0, 32'h1234, 1, b2,    1, 0, 0, 32'h1220, 0, '0);
    vecs[3] = mk(1, 0, 32'h1234, 1, b3,    1, 0, 0, 32'h1220, 0, '0);
    vecs[4] = mk(1, 0, 32'h1234, 1, b4,    0, 0, 0, 32'h1220, 0, '0);
    vecs[5] = mk(1, 0, 32'h1234, 0, 64'h0, 0, 0, 1, 32'h1220, 1, {b4, b3, b2, b1});
    vecs[6] = mk(0, 0, 32'h1234, 0, 64'h0, 0, 0, 0, 32'h1220, 1, {b4, b3, b2, b1});
    vecs[7] = mk(0, 0, 32'h1234, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 32'h1220, 1, {b4, b3, b2, b1});
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("proto_before_stray", 256'(proto_err_o), 256'(1'b0));
      read_i    = vecs[i].rd;
      write_i   = vecs[i].wr;
      address_i = vecs[i].addr;
      resp_i    = vecs[i].rsp;
      burst_i   = vecs[i].beat;
      tick();
      check($sformatf("vec%0d_read_o", i), 256'(read_o), 256'(vecs[i].e_rd));
      check($sformatf("vec%0d_write_o", i), 256'(write_o), 256'(vecs[i].e_wr));
      check($sformatf("vec%0d_resp_o", i), 256'(resp_o), 256'(vecs[i].e_resp));
      check($sformatf("vec%0d_address_o", i), 256'(address_o), 256'(vecs[i].e_addr));
      if (vecs[i].chk_line) check($sformatf("vec%0d_line_o", i), line_o, vecs[i].e_line);
    end
    resp_i = 1'b0; burst_i = '0;
    tick();
    check("stray_resp_proto", 256'(proto_err_o), 256'(exp_proto));
    check("stray_resp_line_o", line_o, {b4, b3, b2, b1});

    // Write to 0x80 with three stall cycles before each acknowledge.
    resp_base = resp_cnt;
    write_i = 1'b1; address_i = 32'h80; line_i = w_line;
    tick();
    check("wr_accept_write_o", 256'(write_o), 256'(1'b1));
    check("wr_accept_address_o", 256'(address_o), 256'(32'h80));
    check("wr_accept_burst_o", 256'(burst_o), 256'(slot(w_line, 0)));
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 3; s++) begin
        resp_i = 1'b0;
        tick();
        check($sformatf("wr_stall%0d_burst_o", k), 256'(burst_o), 256'(slot(w_line, k)));
        check($sformatf("wr_stall%0d_write_o", k), 256'(write_o), 256'(1'b1));
        check($sformatf("wr_stall%0d_read_o", k), 256'(read_o), 256'(1'b0));
      end
      resp_i = 1'b1;
      tick();
      check($sformatf("wr_ack%0d_write_o", k), 256'(write_o), 256'(k < 3));
      if (k < 3) check($sformatf("wr_ack%0d_burst_o", k), 256'(burst_o), 256'(slot(w_line, k + 1)));
    end
    resp_i = 1'b0;
    tick();
    check("wr_done_resp_o", 256'(resp_o), 256'(1'b1));
    check("wr_done_line_o", line_o, w_line);
    write_i = 1'b0;
    tick();
    check("wr_after_resp_o", 256'(resp_o), 256'(1'b0));
    check("wr_after_write_o", 256'(write_o), 256'(1'b0));
    check("wr_resp_pulses", 256'(resp_cnt - resp_base), 256'(1));

    // Both requests high in IDLE: the read wins and write_o never rises.
    write_i = 1'b1; line_i = w_line;
    read_burst(32'h47, d4, 1'b0);
    write_i = 1'b0;
    tick();
    check("both_after_write_o", 256'(write_o), 256'(1'b0));
    check("both_after_read_o", 256'(read_o), 256'(1'b0));
    check("both_proto", 256'(proto_err_o), 256'(exp_proto));

    // read_i held across resp_o starts a second burst, one pulse per burst.
    resp_base = resp_cnt;
    read_burst(32'h300, d1, 1'b1);
    read_burst(32'h300, d2, 1'b0);
    tick();
    check("b2b_idle_read_o", 256'(read_o), 256'(1'b0));
    check("b2b_idle_resp_o", 256'(resp_o), 256'(1'b0));
    check("b2b_resp_pulses", 256'(resp_cnt - resp_base), 256'(2));

    // Asynchronous reset after two beats of a read, then a clean read.
    resp_base = resp_cnt;
    read_i = 1'b1; address_i = 32'h200;
    tick();
    for (int k = 0; k < 2; k++) begin
      resp_i = 1'b1; burst_i = slot(d3, k);
      tick();
    end
    resp_i = 1'b0; burst_i = '0;
    #2 rst = 1'b1;
    #1;
    check("arst_read_o", 256'(read_o), 256'(1'b0));
    check("arst_address_o", 256'(address_o), 256'(32'h0));
    check("arst_line_o", line_o, 256'h0);
    check("arst_resp_o", 256'(resp_o), 256'(1'b0));
    #1 rst = 1'b0;
    read_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("arst_quiet_resp_o", 256'(resp_o), 256'(1'b0));
      check("arst_quiet_read_o", 256'(read_o), 256'(1'b0));
    end
    check("arst_no_pulse", 256'(resp_cnt - resp_base), 256'(0));
    read_burst(32'h200, d3, 1'b0);
    tick();
    check("arst_recover_resp_o", 256'(resp_o), 256'(1'b0));

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected completion before 50000");
    $fatal(1, "timeout");
  end

endmodule
